dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sits between the CPU datapath and the word-wide data memory.
- Turns CPU byte-addressed loads and stores of byte, halfword or word size into word accesses on the data memory.
- Sub-word stores become a read-modify-write that stalls the CPU for one cycle; loads extract the addressed lane and extend it.
- Detects misaligned accesses and counts RMW operations for debug.

Parameters:
- AW, 14, word-address width driven to the data memory (16384 words).
- CNT_W, 16, width of the saturating RMW counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- cpu_req  input  1  CPU memory access valid this cycle
- cpu_wr  input  1  1 = store, 0 = load (qualified by cpu_req)
- cpu_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
- cpu_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend
- cpu_addr  input  32  byte address
- cpu_wdata  input  32  store data, right-justified for sub-word
- cpu_rdata  output  32  load result, combinational
- cpu_stall  output  1  CPU must hold all request inputs and not advance
- mem_wr  output  1  data memory write enable
- mem_addr  output  32  word index, {(32-AW) zeros, cpu_addr[AW+1:2]}
- mem_writedata  output  32  data memory write data
- mem_readdata  input  32  data memory read data, combinational when mem_wr=0
- align_err  output  1  sticky misalignment flag
- err_addr  output  32  byte address of the first misaligned access
- rmw_count  output  CNT_W  number of completed RMW writes, saturating

Behaviour:
- Little-endian: lane = cpu_addr[1:0]; byte n occupies bits [8n+7:8n]; halfword at addr[1]=1 occupies [31:16].
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No memory write; cpu_rdata=0; no stall.
  - align_err set on the next edge; err_addr captured only if align_err was 0.
- Loads: mem_addr from cpu_addr, mem_wr=0; cpu_rdata is the selected lane, extended per cpu_unsigned; word loads pass through. Zero latency, no stall. cpu_rdata=0 when cpu_req=0.
- Aligned word store in IDLE: mem_wr=1, mem_writedata=cpu_wdata, combinational. Committed on the same edge, no stall.
- FSM states IDLE and RMW_WR.
- IDLE, cpu_req and cpu_wr and sub-word and aligned:
  - cpu_stall=1, mem_wr=0, mem_addr from cpu_addr.
  - On the edge, latch merged = mem_readdata with the addressed lane replaced by the low 8/16 bits of cpu_wdata.
  - Latch the word address; go to RMW_WR.
- RMW_WR:
  - mem_wr=1, mem_addr=latched address, mem_writedata=latched merged, cpu_stall=0.
  - The CPU advances on this edge; rmw_count increments unless it is all-ones.
  - Return to IDLE unconditionally. CPU inputs are ignored in this cycle.
- Idle outputs: mem_wr=0, mem_writedata=cpu_wdata, cpu_stall=0.
- Reset (asynchronous, any time including mid-RMW):
  - State IDLE, latched word and address = 0, align_err=0, err_addr=0, rmw_count=0.
  - A pending RMW is abandoned: no write occurs.
  - Combinational outputs then follow IDLE rules.
- mem_wr is never high for a misaligned request or when cpu_req=0.
- Latency:
  - Loads: 0 cycles.
  - Word stores: 1 edge.
  - Sub-word stores: 2 edges, 1 stall cycle.

Test Plan:
- Word 0x10 (byte 0x40) = 0x11223344; load byte 0x42 unsigned -> cpu_rdata=0x00000022. Load halfword 0x42 signed with word 0x8822_3344 -> 0xFFFF8822. No stall.
- Store byte 0xAA to 0x41 -> cycle 1: cpu_stall=1, mem_wr=0. Cycle 2: mem_wr=1, mem_addr=0x10, mem_writedata=0x1122AA44, stall=0. rmw_count=1.
- Store halfword 0xBEEF to 0x42, prior 0x1122AA44 -> writedata 0xBEEFAA44. Next word store 0xDEADBEEF to 0x44 -> single-cycle mem_wr, mem_addr=0x11, no stall.
- Store word to 0x46 -> mem_wr stays 0, align_err=1, err_addr=0x46. Then halfword load at 0x43 -> cpu_rdata=0, err_addr still 0x46.
- Assert reset during the RMW_WR cycle -> mem_wr drops immediately, memory unchanged, rmw_count=0, align_err=0.
- Force rmw_count to all-ones and perform one more byte store -> count stays 0xFFFF, write still occurs.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module   : dmem_access_ctrl
// Purpose  : Byte/halfword/word CPU loads and stores onto a word-wide data
//            memory, with read-modify-write for sub-word stores.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_access_ctrl #(
    parameter int AW    = 14,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_wr,
    input  logic [1:0]       cpu_size,
    input  logic             cpu_unsigned,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_stall,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_writedata,
    input  logic [31:0]      mem_readdata,
    output logic             align_err,
    output logic [31:0]      err_addr,
    output logic [CNT_W-1:0] rmw_count
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_RMW_WR = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_t           r_state;
    logic [31:0]      r_merged;
    logic [AW-1:0]    r_waddr;
    logic             r_align_err;
    logic [31:0]      r_err_addr;
    logic [CNT_W-1:0] r_rmw_count;

    logic             w_is_byte;
    logic             w_is_half;
    logic             w_is_word;
    logic             w_misal;
    logic [1:0]       w_lane;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_merged;
    logic [31:0]      w_word_addr;
    logic             w_unused_addr;

    assign w_is_word   = cpu_size[1];
    assign w_is_half   = (cpu_size == 2'b01);
    assign w_is_byte   = (cpu_size == 2'b00);
    assign w_lane      = cpu_addr[1:0];
    assign w_misal     = (w_is_half & cpu_addr[0]) | (w_is_word & (|cpu_addr[1:0]));
    assign w_word_addr = {{(32-AW){1'b0}}, cpu_addr[AW+1:2]};
    assign w_unused_addr = ^cpu_addr[31:AW+2];

    assign w_byte = 8'(mem_readdata >> {w_lane, 3'b000});
    assign w_half = cpu_addr[1] ? mem_readdata[31:16] : mem_readdata[15:0];

    always_comb begin
        w_load = mem_readdata;
        if (w_is_byte) begin
            w_load = {{24{~cpu_unsigned & w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            w_load = {{16{~cpu_unsigned & w_half[15]}}, w_half};
        end
    end

    // Current memory word with the addressed lane overwritten by store data.
    always_comb begin
        w_merged = mem_readdata;
        if (w_is_byte) begin
            w_merged[{w_lane, 3'b000} +: 8] = cpu_wdata[7:0];
        end else if (cpu_addr[1]) begin
            w_merged[31:16] = cpu_wdata[15:0];
        end else begin
            w_merged[15:0] = cpu_wdata[15:0];
        end
    end

    always_comb begin
        cpu_rdata     = 32'h0;
        cpu_stall     = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = w_word_addr;
        mem_writedata = cpu_wdata;
        if (r_state == S_RMW_WR) begin
            mem_wr        = 1'b1;
            mem_addr      = {{(32-AW){1'b0}}, r_waddr};
            mem_writedata = r_merged;
        end else if (cpu_req && !w_misal) begin
            if (!cpu_wr) begin
                cpu_rdata = w_load;
            end else if (w_is_word) begin
                mem_wr = 1'b1;
            end else begin
                cpu_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_merged    <= 32'h0;
            r_waddr     <= '0;
            r_align_err <= 1'b0;
            r_err_addr  <= 32'h0;
            r_rmw_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req && w_misal) begin
                        r_align_err <= 1'b1;
                        if (!r_align_err) begin
                            r_err_addr <= cpu_addr;
                        end
                    end else if (cpu_req && cpu_wr && !w_is_word) begin
                        r_merged <= w_merged;
                        r_waddr  <= cpu_addr[AW+1:2];
                        r_state  <= S_RMW_WR;
                    end
                end
                S_RMW_WR: begin
                    if (r_rmw_count != C_CNT_MAX) begin
                        r_rmw_count <= r_rmw_count + 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign align_err = r_align_err;
    assign err_addr  = r_err_addr;
    assign rmw_count = r_rmw_count;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Purpose  : Directed self-checking bench for dmem_access_ctrl with a word
//            memory model; a second 2-bit-counter instance shows saturation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_wr;
    logic [1:0]  cpu_size;
    logic        cpu_unsigned;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        align_err;
    logic [31:0] err_addr;
    logic [15:0] rmw_count;

    logic [31:0] s_rdata, s_addr, s_wdata, s_err_addr;
    logic        s_stall, s_wr, s_align_err;
    logic [1:0]  s_count;

    logic [31:0] mem [0:16383];

    int n_cmp = 0;
    int n_err = 0;

    dmem_access_ctrl #(.AW(14), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
        .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .align_err(align_err), .err_addr(err_addr),
        .rmw_count(rmw_count)
    );

    dmem_access_ctrl #(.AW(14), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
        .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(s_rdata), .cpu_stall(s_stall),
        .mem_wr(s_wr), .mem_addr(s_addr), .mem_writedata(s_wdata),
        .mem_readdata(mem_readdata), .align_err(s_align_err), .err_addr(s_err_addr),
        .rmw_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_readdata = mem[mem_addr[13:0]];

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr[13:0]] <= mem_writedata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
        cpu_req      = req;
        cpu_wr       = wr;
        cpu_size     = sz;
        cpu_unsigned = uns;
        cpu_addr     = a;
        cpu_wdata    = d;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic word_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_waddr);
        drive(1'b1, 1'b1, 2'b10, 1'b0, a, d);
        @(negedge clk);
        check("wst_wr", {31'b0, mem_wr}, 32'h1);
        check("wst_addr", mem_addr, exp_waddr);
        check("wst_stall", {31'b0, cpu_stall}, 32'h0);
        tick;
        idle;
    endtask

    task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, sz, uns, a, 32'h0);
        @(negedge clk);
        check("load_data", cpu_rdata, exp);
        check("load_nowr", {31'b0, mem_wr, cpu_stall}, 32'h0);
        tick;
        idle;
    endtask

    task automatic sub_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_waddr, input logic [31:0] exp_data);
        drive(1'b1, 1'b1, sz, 1'b0, a, d);
        @(negedge clk);
        check("rmw_rd_stall", {31'b0, cpu_stall}, 32'h1);
        check("rmw_rd_nowr", {31'b0, mem_wr}, 32'h0);
        tick;
        @(negedge clk);
        check("rmw_wr_en", {31'b0, mem_wr}, 32'h1);
        check("rmw_wr_addr", mem_addr, exp_waddr);
        check("rmw_wr_data", mem_writedata, exp_data);
        check("rmw_wr_stall", {31'b0, cpu_stall}, 32'h0);
        tick;
        idle;
    endtask

    initial begin
        reset = 1'b1;
        idle;
        repeat (2) tick;
        check("rst_count", {16'h0, rmw_count}, 32'h0);
        check("rst_align", {31'b0, align_err}, 32'h0);
        check("rst_erraddr", err_addr, 32'h0);
        check("rst_outs", {30'b0, mem_wr, cpu_stall}, 32'h0);
        reset = 1'b0;
        tick;

        // Word-store with cpu_req low must not write.
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hFFFF_FFFF);
        @(negedge clk);
        check("noreq_wr", {31'b0, mem_wr}, 32'h0);
        check("noreq_rdata", cpu_rdata, 32'h0);
        tick;

        word_store(32'h40, 32'h1122_3344, 32'h10);
        load(2'b00, 1'b1, 32'h42, 32'h0000_0022);
        word_store(32'h40, 32'h8822_3344, 32'h10);
        load(2'b01, 1'b0, 32'h42, 32'hFFFF_8822);
        load(2'b00, 1'b0, 32'h43, 32'hFFFF_FF88);
        load(2'b01, 1'b1, 32'h42, 32'h0000_8822);
        load(2'b11, 1'b0, 32'h40, 32'h8822_3344);
        word_store(32'h40, 32'h1122_3344, 32'h10);

        sub_store(2'b00, 32'h41, 32'h0000_00AA, 32'h10, 32'h1122_AA44);
        check("cnt_1", {16'h0, rmw_count}, 32'd1);
        sub_store(2'b01, 32'h42, 32'h0000_BEEF, 32'h10, 32'hBEEF_AA44);
        check("cnt_2", {16'h0, rmw_count}, 32'd2);
        word_store(32'h44, 32'hDEAD_BEEF, 32'h11);

        // Misaligned word store, then misaligned halfword load.
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h46, 32'h1234_5678);
        @(negedge clk);
        check("mis_st_nowr", {30'b0, mem_wr, cpu_stall}, 32'h0);
        tick;
        check("mis_align", {31'b0, align_err}, 32'h1);
        check("mis_erraddr", err_addr, 32'h46);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h43, 32'h0);
        @(negedge clk);
        check("mis_ld_rdata", cpu_rdata, 32'h0);
        check("mis_ld_nowr", {30'b0, mem_wr, cpu_stall}, 32'h0);
        tick;
        idle;
        check("mis_erraddr_kept", err_addr, 32'h46);
        load(2'b10, 1'b0, 32'h44, 32'hDEAD_BEEF);

        sub_store(2'b00, 32'h40, 32'h0000_0055, 32'h10, 32'hBEEF_AA55);
        check("cnt_3", {16'h0, rmw_count}, 32'd3);
        check("sat_cnt_3", {30'b0, s_count}, 32'd3);
        sub_store(2'b00, 32'h43, 32'hFFFF_FF66, 32'h10, 32'h66EF_AA55);
        check("cnt_4", {16'h0, rmw_count}, 32'd4);
        check("sat_cnt_hold", {30'b0, s_count}, 32'd3);
        load(2'b10, 1'b0, 32'h40, 32'h66EF_AA55);

        // Reset lands in the write half of an RMW: no write may reach memory.
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h44, 32'h0000_0077);
        tick;
        #2;
        check("midrmw_wr_before", {31'b0, mem_wr}, 32'h1);
        reset = 1'b1;
        #1;
        check("midrmw_wr_drop", {31'b0, mem_wr}, 32'h0);
        idle;
        tick;
        check("midrmw_count", {16'h0, rmw_count}, 32'h0);
        check("midrmw_align", {31'b0, align_err}, 32'h0);
        check("midrmw_erraddr", err_addr, 32'h0);
        reset = 1'b0;
        tick;
        load(2'b10, 1'b0, 32'h44, 32'hDEAD_BEEF);
        load(2'b00, 1'b1, 32'h44, 32'h0000_00EF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
